window_generator_3x3: RTL and testbench

//   Streaming 3x3 neighbourhood producer for the convolution pipeline.

---
 rtl/window_generator_3x3.sv | 163 ++++++++++++++++
 tb/tb_window_generator_3x3.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/window_generator_3x3.sv
// -----------------------------------------------------------------------------
// window_generator_3x3
//
// Streaming 3x3 neighbourhood producer. Raster-order pixels arrive one per
// valid cycle; two line buffers hold the previous two rows. Each time a
// fully-interior pixel (row >= 2, col >= 2) is accepted, the 3x3 window that
// ends at that pixel is presented for exactly one cycle. No border padding.
//
// Ports
//   i_clk               clock, all logic on rising edge
//   i_rst               synchronous reset, active-high
//   i_pixel             incoming raster-order pixel
//   i_pixel_valid       pixel accepted this cycle when high (no backpressure)
//   o_pixel_data        3x3 window, byte k = row*3 + col (row0 = top, col0 = left)
//   o_pixel_data_valid  one-cycle pulse: o_pixel_data holds a new window
//   o_frame_done        one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module window_generator_3x3 #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int PIX_W      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [PIX_W-1:0]     i_pixel,
    input  logic                 i_pixel_valid,
    output logic [9*PIX_W-1:0]   o_pixel_data,
    output logic                 o_pixel_data_valid,
    output logic                 o_frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [CW-1:0]       col_r;
    logic [CW-1:0]       col_next_s;
    logic [RW-1:0]       row_r;
    logic [RW-1:0]       row_next_s;
    logic                col_last_s;
    logic                row_last_s;
    logic                frame_last_s;
    logic                win_emit_s;

    // LB0 holds row r-2, LB1 holds row r-1; neither is ever cleared.
    logic [PIX_W-1:0]    lb0_r [IMG_WIDTH];
    logic [PIX_W-1:0]    lb1_r [IMG_WIDTH];

    // Internal shift window; it also moves during non-emitting pixels so the
    // three columns are rebuilt from the current row before col 2 is reached.
    logic [9*PIX_W-1:0]  win_r;
    logic [9*PIX_W-1:0]  win_next_s;

    assign col_last_s = (col_r == CW'(IMG_WIDTH - 1));
    assign row_last_s = (row_r == RW'(IMG_HEIGHT - 1));

    // Counter, FSM next-state and emit/frame-end decode for the accepted pixel.
    always_comb begin
        col_next_s   = col_r;
        row_next_s   = row_r;
        state_next_s = state_r;
        win_emit_s   = 1'b0;
        frame_last_s = 1'b0;
        if (i_pixel_valid) begin
            win_emit_s = (state_r == ST_ACTIVE) && (col_r >= CW'(2));
            if (col_last_s) begin
                col_next_s = '0;
                if (row_last_s) begin
                    row_next_s   = '0;
                    frame_last_s = 1'b1;
                end else begin
                    row_next_s = row_r + RW'(1);
                end
            end else begin
                col_next_s = col_r + CW'(1);
            end
            case (state_r)
                ST_FILL: begin
                    if (col_last_s && (row_r == RW'(1))) begin
                        state_next_s = ST_ACTIVE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end
                ST_ACTIVE: begin
                    if (frame_last_s) begin
                        state_next_s = ST_FILL;
                    end else begin
                        state_next_s = ST_ACTIVE;
                    end
                end
                default: state_next_s = ST_FILL;
            endcase
        end else begin
            win_emit_s = 1'b0;
        end
    end

    // Shift the window left by one column and insert {LB0[c], LB1[c], pixel}.
    always_comb begin
        win_next_s = win_r;
        for (int rr = 0; rr < 3; rr++) begin
            win_next_s[(rr*3+0)*PIX_W +: PIX_W] = win_r[(rr*3+1)*PIX_W +: PIX_W];
            win_next_s[(rr*3+1)*PIX_W +: PIX_W] = win_r[(rr*3+2)*PIX_W +: PIX_W];
        end
        win_next_s[2*PIX_W +: PIX_W] = lb0_r[col_r];
        win_next_s[5*PIX_W +: PIX_W] = lb1_r[col_r];
        win_next_s[8*PIX_W +: PIX_W] = i_pixel;
    end

    // State and position counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_FILL;
            col_r   <= '0;
            row_r   <= '0;
        end else begin
            state_r <= state_next_s;
            col_r   <= col_next_s;
            row_r   <= row_next_s;
        end
    end

    // Internal window shift register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            win_r <= '0;
        end else if (i_pixel_valid) begin
            win_r <= win_next_s;
        end
    end

    // Line buffers: column c moves up one row, new pixel lands in LB1.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_pixel_valid) begin
            lb0_r[col_r] <= lb1_r[col_r];
            lb1_r[col_r] <= i_pixel;
        end
    end

    // Registered outputs; data only updates on an emitted window so it holds
    // steady between valid pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_frame_done       <= 1'b0;
        end else begin
            o_pixel_data_valid <= win_emit_s;
            o_frame_done       <= frame_last_s;
            if (win_emit_s) begin
                o_pixel_data <= win_next_s;
            end
        end
    end

endmodule

// File: tb/tb_window_generator_3x3.sv
module tb_window_generator_3x3;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int DW = 9 * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pix;
    logic          pix_v;
    logic [DW-1:0] pd;
    logic          pdv;
    logic          fd;

    always #5 clk = ~clk;

    window_generator_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) u_dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pixel            (pix),
        .i_pixel_valid      (pix_v),
        .o_pixel_data       (pd),
        .o_pixel_data_valid (pdv),
        .o_frame_done       (fd)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          done;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] t1_win[4];
    logic [DW-1:0] last_data = '0;
    logic [PW-1:0] img [H][W];
    int            n_vec  = 0;
    int            n_bad  = 0;
    int            n_win  = 0;
    int            n_done = 0;
    int            cy     = 0;
    int            mr     = 0;
    int            mc     = 0;
    logic          rst_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cy       <= cy + 1;
        rst_seen <= rst;
    end

    // Monitor: compare outputs at the falling edge against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cy) begin
            check_eq("window_late", cy, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (rst_seen) begin
            check_eq("rst_valid", pdv, 73'd0);
            check_eq("rst_done", fd, 73'd0);
            check_eq("rst_data", pd, 73'd0);
            last_data = '0;
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cy) begin
            e = exp_q.pop_front();
            check_eq("valid", pdv, 73'd1);
            check_eq("window", pd, e.data);
            check_eq("frame_done", fd, e.done);
            last_data = pd;
            got_q.push_back(pd);
            n_win++;
            if (fd) n_done++;
        end else begin
            check_eq("idle_valid", pdv, 73'd0);
            check_eq("idle_done", fd, 73'd0);
            check_eq("hold_data", pd, last_data);
            if (pdv) n_win++;
            if (fd) n_done++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pix_v = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        pix_v = 1'b0;
        mr    = 0;
        mc    = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drive one pixel after 'gap' idle cycles and record the expected window.
    task automatic send(input logic [PW-1:0] p, input int gap);
        exp_t          e;
        logic [DW-1:0] w;
        idle(gap);
        @(posedge clk);
        #1;
        pix   = p;
        pix_v = 1'b1;
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            w = '0;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    w[(rr*3+cc)*PW +: PW] = img[mr-2+rr][mc-2+cc];
            e.data = w;
            e.done = (mr == H-1) && (mc == W-1);
            e.cyc  = cy + 1;
            exp_q.push_back(e);
        end
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic send_frame(input int base, input int max_gap, input bit rnd);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(rnd ? PW'($urandom_range(0, 255)) : PW'(base + 4*r + c),
                     (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic clear_stats();
        n_win  = 0;
        n_done = 0;
        got_q.delete();
    endtask

    initial begin
        rst   = 1'b1;
        pix   = '0;
        pix_v = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Continuous frame with pixel = 4r+c
        clear_stats();
        send_frame(0, 0, 1'b0);
        idle(3);
        check_eq("t1_count", n_win, 73'd4);
        check_eq("t1_done_count", n_done, 73'd1);
        if (got_q.size() == 4) begin
            check_eq("t1_first", got_q[0], 73'h0a_09_08_06_05_04_02_01_00);
            check_eq("t1_last", got_q[3], 73'h0f_0e_0d_0b_0a_09_07_06_05);
            for (int i = 0; i < 4; i++) t1_win[i] = got_q[i];
        end else begin
            for (int i = 0; i < 4; i++) t1_win[i] = '0;
        end

        // Same frame with random gaps
        clear_stats();
        send_frame(0, 3, 1'b0);
        idle(5);
        check_eq("t2_count", n_win, 73'd4);
        for (int i = 0; i < 4; i++)
            check_eq("t2_same_as_t1", (got_q.size() > i) ? got_q[i] : '0, t1_win[i]);

        // Two back-to-back frames with different data
        clear_stats();
        send_frame(8'h80, 0, 1'b0);
        send_frame(8'h30, 0, 1'b0);
        idle(3);
        check_eq("t3_count", n_win, 73'd8);
        check_eq("t3_done_count", n_done, 73'd2);

        // Reset after 9 pixels, then a full frame
        clear_stats();
        for (int i = 0; i < 9; i++) send(PW'(8'hf0 + i), 0);
        do_reset();
        send_frame(8'h40, 1, 1'b0);
        idle(3);
        check_eq("t4_count", n_win, 73'd4);
        check_eq("t4_done_count", n_done, 73'd1);

        // Reset with non-zero held output; monitor checks zeros during/after
        do_reset();
        idle(2);

        // Random frames, back-to-back with sparse gaps
        clear_stats();
        for (int f = 0; f < 12; f++) send_frame(0, (f % 3 == 0) ? 0 : 2, 1'b1);
        idle(4);
        check_eq("t6_count", n_win, 73'd48);
        check_eq("t6_done_count", n_done, 73'd12);
        check_eq("queue_empty", exp_q.size(), 73'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
